// File: rtl/apple_spawn_controller.sv
// Apple spawn sequencer: steps the position generator, range-checks and
// occupancy-checks each candidate, retries a bounded number of times, then
// publishes either the validated position or a fixed fallback.
module apple_spawn_controller #(
    parameter int unsigned MAX_TRIES  = 8,
    parameter int unsigned GEN_LAT    = 1,
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned Y_MAX      = 479,
    parameter int unsigned FALLBACK_X = 320,
    parameter int unsigned FALLBACK_Y = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spawn_req,
    output logic        gen_step,
    input  logic [9:0]  gen_x,
    input  logic [9:0]  gen_y,
    output logic        chk_req,
    output logic [9:0]  chk_x,
    output logic [9:0]  chk_y,
    input  logic        chk_ack,
    input  logic        chk_hit,
    output logic [9:0]  apple_x,
    output logic [9:0]  apple_y,
    output logic        apple_valid,
    output logic        spawn_done,
    output logic        spawn_busy,
    output logic        used_fallback,
    output logic [7:0]  spawn_count
);

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned TRY_W    = 4;
    localparam int unsigned COUNT_W  = 8;
    localparam int unsigned SETTLE_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_CHECK,
        S_PLACE,
        S_FALLBACK
    } state_t;

    state_t                r_state;
    logic                  r_gen_step;
    logic                  r_chk_req;
    logic [COORD_W-1:0]    r_chk_x;
    logic [COORD_W-1:0]    r_chk_y;
    logic [COORD_W-1:0]    r_apple_x;
    logic [COORD_W-1:0]    r_apple_y;
    logic                  r_apple_valid;
    logic                  r_spawn_done;
    logic                  r_busy;
    logic                  r_used_fallback;
    logic [COUNT_W-1:0]    r_spawn_count;
    logic [TRY_W-1:0]      r_try;
    logic                  r_pending;
    logic [SETTLE_W-1:0]   r_settle;

    logic [TRY_W-1:0]      w_try_next;
    logic                  w_tries_exhausted;
    logic                  w_in_range;

    // Retry bookkeeping and candidate bounds check (unsigned, 10 bits)
    assign w_try_next        = r_try + TRY_W'(1);
    assign w_tries_exhausted = (w_try_next == TRY_W'(MAX_TRIES));
    assign w_in_range        = (gen_x <= COORD_W'(X_MAX)) && (gen_y <= COORD_W'(Y_MAX));

    // Spawn sequencer: state and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_gen_step      <= 1'b0;
            r_chk_req       <= 1'b0;
            r_chk_x         <= '0;
            r_chk_y         <= '0;
            r_apple_x       <= COORD_W'(FALLBACK_X);
            r_apple_y       <= COORD_W'(FALLBACK_Y);
            r_apple_valid   <= 1'b0;
            r_spawn_done    <= 1'b0;
            r_busy          <= 1'b0;
            r_used_fallback <= 1'b0;
            r_spawn_count   <= '0;
            r_try           <= '0;
            r_pending       <= 1'b0;
            r_settle        <= '0;
        end else begin
            r_spawn_done <= 1'b0;

            // One-deep request memory while a spawn is in flight
            if (spawn_req && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (spawn_req || r_pending) begin
                        r_pending     <= 1'b0;
                        r_try         <= '0;
                        r_apple_valid <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_STEP;
                    end
                end

                S_STEP: begin
                    r_gen_step <= 1'b1;
                    r_settle   <= SETTLE_W'(GEN_LAT - 1);
                    r_state    <= S_SETTLE;
                end

                S_SETTLE: begin
                    // First cycle: the generator consumes the strobe; then count out its latency
                    if (r_gen_step) begin
                        r_gen_step <= 1'b0;
                    end else if (r_settle != '0) begin
                        r_settle <= r_settle - SETTLE_W'(1);
                    end else begin
                        r_chk_x <= gen_x;
                        r_chk_y <= gen_y;
                        if (w_in_range) begin
                            r_chk_req <= 1'b1;
                            r_state   <= S_CHECK;
                        end else begin
                            r_try   <= w_try_next;
                            r_state <= w_tries_exhausted ? S_FALLBACK : S_STEP;
                        end
                    end
                end

                S_CHECK: begin
                    if (chk_ack) begin
                        r_chk_req <= 1'b0;
                        if (!chk_hit) begin
                            r_state <= S_PLACE;
                        end else begin
                            r_try   <= w_try_next;
                            r_state <= w_tries_exhausted ? S_FALLBACK : S_STEP;
                        end
                    end
                end

                S_PLACE: begin
                    r_apple_x       <= r_chk_x;
                    r_apple_y       <= r_chk_y;
                    r_apple_valid   <= 1'b1;
                    r_spawn_done    <= 1'b1;
                    r_used_fallback <= 1'b0;
                    r_spawn_count   <= r_spawn_count + COUNT_W'(1);
                    r_busy          <= 1'b0;
                    r_state         <= S_IDLE;
                end

                S_FALLBACK: begin
                    r_apple_x       <= COORD_W'(FALLBACK_X);
                    r_apple_y       <= COORD_W'(FALLBACK_Y);
                    r_apple_valid   <= 1'b1;
                    r_spawn_done    <= 1'b1;
                    r_used_fallback <= 1'b1;
                    r_spawn_count   <= r_spawn_count + COUNT_W'(1);
                    r_busy          <= 1'b0;
                    r_state         <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gen_step      = r_gen_step;
    assign chk_req       = r_chk_req;
    assign chk_x         = r_chk_x;
    assign chk_y         = r_chk_y;
    assign apple_x       = r_apple_x;
    assign apple_y       = r_apple_y;
    assign apple_valid   = r_apple_valid;
    assign spawn_done    = r_spawn_done;
    assign spawn_busy    = r_busy;
    assign used_fallback = r_used_fallback;
    assign spawn_count   = r_spawn_count;

endmodule

// File: tb/tb_apple_spawn_controller.sv
// Bench for apple_spawn_controller: generator and checker models plus a
// placement scoreboard; each scenario task checks its own expectations.
module tb_apple_spawn_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       spawn_req = 1'b0;
    logic       gen_step;
    logic [9:0] gen_x = '0;
    logic [9:0] gen_y = '0;
    logic       chk_req;
    logic [9:0] chk_x;
    logic [9:0] chk_y;
    logic       chk_ack = 1'b0;
    logic       chk_hit = 1'b0;
    logic [9:0] apple_x;
    logic [9:0] apple_y;
    logic       apple_valid;
    logic       spawn_done;
    logic       spawn_busy;
    logic       used_fallback;
    logic [7:0] spawn_count;

    int checks = 0;
    int failures = 0;

    logic [19:0] gen_q[$];   // {x, y} candidates the generator will produce
    bit          resp_q[$];  // hit bits the checker will answer with
    logic [20:0] exp_q[$];   // {fallback, x, y} expected placements
    int          ack_delay = 0;
    int          gen_steps = 0;
    int          chk_reqs = 0;
    int          done_cnt = 0;
    int          exp_count = 0;

    apple_spawn_controller #(
        .MAX_TRIES(8), .GEN_LAT(1), .X_MAX(639), .Y_MAX(479),
        .FALLBACK_X(320), .FALLBACK_Y(240)
    ) dut (
        .clock(clock), .reset(reset), .spawn_req(spawn_req),
        .gen_step(gen_step), .gen_x(gen_x), .gen_y(gen_y),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
        .chk_ack(chk_ack), .chk_hit(chk_hit),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .spawn_done(spawn_done), .spawn_busy(spawn_busy),
        .used_fallback(used_fallback), .spawn_count(spawn_count)
    );

    always #5 clock = ~clock;

    // Generator model: advances to the next queued candidate on each strobe
    always begin
        logic [19:0] g;
        @(posedge clock);
        #1;
        if (reset && gen_step) begin
            gen_steps++;
            if (gen_q.size() > 0) begin
                g = gen_q.pop_front();
                gen_x = g[19:10];
                gen_y = g[9:0];
            end
        end
    end

    // Checker model: acks after ack_delay cycles, watches request stability
    always begin
        int wcnt;
        logic [9:0] held_x, held_y;
        @(posedge clock);
        #1;
        if (!reset) begin
            chk_ack = 1'b0;
            wcnt = 0;
        end else if (chk_ack) begin
            chk_ack = 1'b0;
            chk_hit = 1'b0;
            wcnt = 0;
        end else if (chk_req) begin
            if (wcnt == 0) begin
                chk_reqs++;
                held_x = chk_x;
                held_y = chk_y;
            end else begin
                checks++;
                if (chk_x !== held_x || chk_y !== held_y) begin
                    failures++;
                    $display("FAIL chk_stable: got (%0d,%0d) want (%0d,%0d)", chk_x, chk_y, held_x, held_y);
                end
            end
            if (wcnt >= ack_delay) begin
                chk_ack = 1'b1;
                chk_hit = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
            end else begin
                wcnt++;
            end
        end
    end

    // Scoreboard: every spawn_done must match the next expected placement
    always begin
        logic [20:0] e;
        @(posedge clock);
        #2;
        if (reset && spawn_done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got spawn_done=1 want no placement");
            end else begin
                e = exp_q.pop_front();
                exp_count++;
                if (apple_x !== e[19:10] || apple_y !== e[9:0] || used_fallback !== e[20]
                    || apple_valid !== 1'b1 || spawn_count !== 8'(exp_count)) begin
                    failures++;
                    $display("FAIL sb_place: got (%0d,%0d) fb=%0d v=%0d cnt=%0d want (%0d,%0d) fb=%0d v=1 cnt=%0d",
                             apple_x, apple_y, used_fallback, apple_valid, spawn_count,
                             e[19:10], e[9:0], e[20], 8'(exp_count));
                end
            end
        end
    end

    // Watchdog against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_req();
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int start;
        bit ok;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done_cnt > start) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: got no spawn_done want spawn_done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_chk_req(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (chk_req) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_chk_timeout: got chk_req=0 want chk_req=1 within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({gen_step, chk_req, chk_x, chk_y} !== 22'd0) begin
            failures++;
            $display("FAIL reset_chk: got step=%0d req=%0d x=%0d y=%0d want all 0", gen_step, chk_req, chk_x, chk_y);
        end
        checks++;
        if (apple_x !== 10'd320 || apple_y !== 10'd240 || apple_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_apple: got (%0d,%0d) v=%0d want (320,240) v=0", apple_x, apple_y, apple_valid);
        end
        checks++;
        if ({spawn_done, spawn_busy, used_fallback, spawn_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_status: got done=%0d busy=%0d fb=%0d cnt=%0d want 0", spawn_done, spawn_busy, used_fallback, spawn_count);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ack_delay = 0;
        gen_q.push_back({10'd100, 10'd200});
        resp_q.push_back(1'b0);
        exp_q.push_back({1'b0, 10'd100, 10'd200});
        pulse_req();                        // edge 0 sampled the request
        checks++;
        if (spawn_busy !== 1'b1 || gen_step !== 1'b0) begin
            failures++;
            $display("FAIL basic_e0: got busy=%0d step=%0d want busy=1 step=0", spawn_busy, gen_step);
        end
        tick();                             // edge 1
        checks++;
        if (gen_step !== 1'b1) begin
            failures++;
            $display("FAIL basic_step_e1: got %0d want 1", gen_step);
        end
        tick();                             // edge 2
        checks++;
        if (gen_step !== 1'b0 || chk_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_e2: got step=%0d req=%0d want 0 0", gen_step, chk_req);
        end
        tick();                             // edge 3
        checks++;
        if (chk_req !== 1'b1 || chk_x !== 10'd100 || chk_y !== 10'd200) begin
            failures++;
            $display("FAIL basic_chk_e3: got req=%0d (%0d,%0d) want req=1 (100,200)", chk_req, chk_x, chk_y);
        end
        tick();                             // edge 4
        checks++;
        if (spawn_done !== 1'b0 || apple_valid !== 1'b0 || chk_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_e4: got done=%0d v=%0d req=%0d want 0 0 0", spawn_done, apple_valid, chk_req);
        end
        tick();                             // edge 5
        checks++;
        if (spawn_done !== 1'b1 || apple_valid !== 1'b1 || apple_x !== 10'd100 || apple_y !== 10'd200
            || spawn_count !== 8'd1 || used_fallback !== 1'b0) begin
            failures++;
            $display("FAIL basic_e5: got done=%0d v=%0d (%0d,%0d) cnt=%0d fb=%0d want 1 1 (100,200) 1 0",
                     spawn_done, apple_valid, apple_x, apple_y, spawn_count, used_fallback);
        end
        tick();
        checks++;
        if (spawn_done !== 1'b0 || spawn_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_e6: got done=%0d busy=%0d want 0 0", spawn_done, spawn_busy);
        end
    endtask

    task automatic test_retry();
        int base_steps, base_done;
        base_steps = gen_steps;
        base_done = done_cnt;
        gen_q.push_back({10'd1, 10'd2});
        gen_q.push_back({10'd3, 10'd4});
        gen_q.push_back({10'd50, 10'd60});
        resp_q.push_back(1'b1);
        resp_q.push_back(1'b1);
        resp_q.push_back(1'b0);
        exp_q.push_back({1'b0, 10'd50, 10'd60});
        pulse_req();
        wait_done(100, "retry");
        repeat (5) tick();
        checks++;
        if (gen_steps - base_steps != 3 || done_cnt - base_done != 1) begin
            failures++;
            $display("FAIL retry_counts: got steps=%0d dones=%0d want 3 1", gen_steps - base_steps, done_cnt - base_done);
        end
        checks++;
        if (apple_x !== 10'd50 || apple_y !== 10'd60) begin
            failures++;
            $display("FAIL retry_apple: got (%0d,%0d) want (50,60)", apple_x, apple_y);
        end
    endtask

    task automatic test_fallback();
        int base_steps;
        base_steps = gen_steps;
        for (int i = 0; i < 8; i++) begin
            gen_q.push_back({10'(10 + i), 10'(20 + i)});
            resp_q.push_back(1'b1);
        end
        exp_q.push_back({1'b1, 10'd320, 10'd240});
        pulse_req();
        wait_done(200, "fallback");
        repeat (3) tick();
        checks++;
        if (gen_steps - base_steps != 8) begin
            failures++;
            $display("FAIL fallback_steps: got %0d want 8", gen_steps - base_steps);
        end
        checks++;
        if (apple_x !== 10'd320 || apple_y !== 10'd240 || used_fallback !== 1'b1 || apple_valid !== 1'b1) begin
            failures++;
            $display("FAIL fallback_apple: got (%0d,%0d) fb=%0d v=%0d want (320,240) 1 1", apple_x, apple_y, used_fallback, apple_valid);
        end
    endtask

    task automatic test_range();
        int base_steps, base_reqs;
        base_steps = gen_steps;
        base_reqs = chk_reqs;
        gen_q.push_back({10'd700, 10'd10});
        gen_q.push_back({10'd12, 10'd470});
        resp_q.push_back(1'b0);
        exp_q.push_back({1'b0, 10'd12, 10'd470});
        pulse_req();
        wait_done(100, "range");
        repeat (3) tick();
        checks++;
        if (chk_reqs - base_reqs != 1 || gen_steps - base_steps != 2) begin
            failures++;
            $display("FAIL range_counts: got reqs=%0d steps=%0d want 1 2", chk_reqs - base_reqs, gen_steps - base_steps);
        end
        checks++;
        if (apple_x !== 10'd12 || apple_y !== 10'd470 || used_fallback !== 1'b0) begin
            failures++;
            $display("FAIL range_apple: got (%0d,%0d) fb=%0d want (12,470) 0", apple_x, apple_y, used_fallback);
        end
    endtask

    task automatic test_back_to_back();
        int base_done, base_count;
        base_done = done_cnt;
        base_count = exp_count;
        ack_delay = 5;
        gen_q.push_back({10'd30, 10'd40});
        gen_q.push_back({10'd70, 10'd80});
        resp_q.push_back(1'b0);
        resp_q.push_back(1'b0);
        exp_q.push_back({1'b0, 10'd30, 10'd40});
        exp_q.push_back({1'b0, 10'd70, 10'd80});
        pulse_req();
        wait_chk_req(20, "b2b");
        pulse_req();                        // pended
        pulse_req();                        // dropped: pending is one deep
        wait_done(100, "b2b_first");
        checks++;
        if (spawn_busy !== 1'b0 || apple_x !== 10'd30 || apple_y !== 10'd40) begin
            failures++;
            $display("FAIL b2b_first: got busy=%0d (%0d,%0d) want 0 (30,40)", spawn_busy, apple_x, apple_y);
        end
        tick();
        checks++;
        if (spawn_busy !== 1'b1 || spawn_done !== 1'b0 || apple_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%0d done=%0d v=%0d want 1 0 0", spawn_busy, spawn_done, apple_valid);
        end
        wait_done(100, "b2b_second");
        repeat (20) tick();
        checks++;
        if (done_cnt - base_done != 2 || spawn_busy !== 1'b0 || spawn_count !== 8'(base_count + 2)) begin
            failures++;
            $display("FAIL b2b_end: got dones=%0d busy=%0d cnt=%0d want 2 0 %0d",
                     done_cnt - base_done, spawn_busy, spawn_count, 8'(base_count + 2));
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        int base_done;
        reset = 1'b0;
        exp_q.delete();
        gen_q.delete();
        resp_q.delete();
        exp_count = 0;
        repeat (2) tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            gen_q.push_back({10'(5 + i), 10'(5 + i)});
            resp_q.push_back(1'b0);
            exp_q.push_back({1'b0, 10'(5 + i), 10'(5 + i)});
            pulse_req();
            wait_done(50, "mid_prep");
        end
        ack_delay = 10;
        gen_q.push_back({10'd8, 10'd8});
        resp_q.push_back(1'b0);
        pulse_req();
        wait_chk_req(20, "mid");
        tick();
        checks++;
        if (spawn_count !== 8'd3 || chk_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got cnt=%0d req=%0d want 3 1", spawn_count, chk_req);
        end
        base_done = done_cnt;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (spawn_count !== 8'd0 || apple_valid !== 1'b0 || chk_req !== 1'b0 || spawn_busy !== 1'b0
            || apple_x !== 10'd320 || apple_y !== 10'd240 || spawn_done !== 1'b0 || chk_x !== 10'd0) begin
            failures++;
            $display("FAIL mid_async: got cnt=%0d v=%0d req=%0d busy=%0d (%0d,%0d) done=%0d cx=%0d want 0 0 0 0 (320,240) 0 0",
                     spawn_count, apple_valid, chk_req, spawn_busy, apple_x, apple_y, spawn_done, chk_x);
        end
        repeat (3) tick();
        resp_q.delete();
        gen_q.delete();
        exp_count = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (15) tick();
        checks++;
        if (done_cnt != base_done || spawn_busy !== 1'b0 || spawn_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_after: got dones=%0d busy=%0d cnt=%0d want 0 0 0", done_cnt - base_done, spawn_busy, spawn_count);
        end
        ack_delay = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_fallback();
        test_range();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending placements want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apple_spawn_controller.md
Name: apple_spawn_controller

Overview:
- Sequences the LFSR-based apple position generator to place an apple.
- On each spawn request it steps the generator, waits for the candidate to settle, and range-checks it.
- It then asks the snake-body/obstacle checker whether the cell is free, retrying up to a bounded count.
- It publishes a validated apple position, or a fixed fallback position, to the game/render logic.

Parameters:
- MAX_TRIES, 8: candidate attempts per spawn before fallback (1..15).
- GEN_LAT, 1: clock cycles from gen_step to a stable generator output (1..7).
- X_MAX, 639: largest legal apple x.
- Y_MAX, 479: largest legal apple y.
- FALLBACK_X, 320: x used when all tries fail.
- FALLBACK_Y, 240: y used when all tries fail.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- spawn_req  in  1  single-cycle pulse (apple eaten / game start) requesting a new apple.
- gen_step  out  1  one-cycle strobe that advances the position generator.
- gen_x  in  10  generator candidate x.
- gen_y  in  10  generator candidate y.
- chk_req  out  1  occupancy check request.
- chk_x  out  10  candidate x under check.
- chk_y  out  10  candidate y under check.
- chk_ack  in  1  checker response valid.
- chk_hit  in  1  candidate occupied; qualified by chk_ack.
- apple_x  out  10  current apple x.
- apple_y  out  10  current apple y.
- apple_valid  out  1  apple position is valid and displayable.
- spawn_done  out  1  one-cycle pulse when a new apple is placed.
- spawn_busy  out  1  high whenever FSM is not IDLE.
- used_fallback  out  1  last placement used the fallback position.
- spawn_count  out  8  placements completed since reset; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - FSM=IDLE.
  - gen_step=0, chk_req=0, chk_x=0, chk_y=0.
  - apple_x=FALLBACK_X, apple_y=FALLBACK_Y, apple_valid=0.
  - spawn_done=0, used_fallback=0, spawn_count=0.
  - try counter=0, pending=0, settle counter=0.
- Reset asserted mid-operation aborts immediately to these values; no spawn_done is issued.
- Deassertion is synchronised externally; the first active edge after release is in IDLE.
- FSM states: IDLE, STEP, SETTLE, CHECK, PLACE, FALLBACK. All outputs are registered.
- IDLE:
  - If spawn_req or pending: clear pending and try counter, set apple_valid=0, go to STEP.
- STEP:
  - gen_step=1 for exactly this cycle.
  - Load settle counter with GEN_LAT-1, go to SETTLE.
- SETTLE:
  - Decrement the counter; at 0, latch gen_x/gen_y into chk_x/chk_y.
  - If gen_x>X_MAX or gen_y>Y_MAX: treat as a hit without issuing chk_req (see retry rule).
  - Otherwise set chk_req=1 and go to CHECK.
- CHECK:
  - chk_req, chk_x and chk_y stay stable until chk_ack is sampled high.
  - chk_req deasserts on the edge that samples chk_ack.
  - chk_ack with chk_hit=0: go to PLACE.
  - chk_ack with chk_hit=1: apply the retry rule.
  - No timeout; the checker guarantees a response.
- Retry rule:
  - Increment the try counter.
  - If it equals MAX_TRIES, go to FALLBACK; else go to STEP.
- PLACE:
  - apple_x/apple_y <= chk_x/chk_y; apple_valid<=1.
  - spawn_done=1 for one cycle; used_fallback<=0; spawn_count++; go to IDLE.
- FALLBACK:
  - apple_x/apple_y <= FALLBACK_X/FALLBACK_Y; apple_valid<=1.
  - spawn_done=1 for one cycle; used_fallback<=1; spawn_count++; go to IDLE.
- Latency, GEN_LAT=1, checker acking in the first CHECK cycle:
  - spawn_req sampled at edge 0 gives STEP at 1, SETTLE at 2, CHECK at 3, PLACE at 4.
  - spawn_done and apple_valid are high after edge 5.
  - Each retry adds 2+GEN_LAT cycles plus the checker wait.
- spawn_req while busy: sets pending (one-deep; further requests are dropped).
  - Pending is serviced from IDLE on the cycle after spawn_done.
- spawn_req in the same cycle as the IDLE→STEP transition: absorbed by that transition, not pended.
- spawn_busy = (state != IDLE).
- apple_x/apple_y hold their old values while apple_valid=0 during a spawn.
- Widths: candidates are compared unsigned at 10 bits; the try counter is 4 bits; spawn_count wraps modulo 256.

Test Plan:
- Reset low, then release; pulse spawn_req; generator gives (100,200); checker acks hit=0 on the first CHECK cycle.
  - Expect: gen_step one cycle at edge 1; chk_req at edge 3 with chk_x=100, chk_y=200.
  - Expect: spawn_done at edge 5; apple=(100,200), apple_valid=1, spawn_count=1, used_fallback=0.
- Checker answers hit=1 twice, then hit=0 on a third candidate (50,60).
  - Expect: exactly 3 gen_step pulses; apple=(50,60); spawn_done once.
- Every check returns hit=1 with MAX_TRIES=8.
  - Expect: 8 gen_step pulses; apple=(320,240); used_fallback=1; apple_valid=1.
- Generator gives (700,10), then (12,470).
  - Expect: no chk_req for the first candidate; second checked and placed; apple=(12,470).
- Checker delays ack 5 cycles while a second spawn_req arrives mid-CHECK.
  - Expect: chk_x/chk_y stable throughout the wait; first placement completes.
  - Expect: second spawn starts the cycle after spawn_done; spawn_count=2 at the end.
- Reset asserted during CHECK with spawn_count=3.
  - Expect: outputs return to reset values asynchronously (spawn_count=0, apple_valid=0, chk_req=0); no spawn_done.
